// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: FSM state type, default parameters and one-hot index helper for fifo_wr_arbiter
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) oh2idx = 3'(i);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: one-hot pick of the first asserted request after last_gnt, wrapping modulo NUM_REQ
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int LW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LW-1:0]      last_gnt,
    output logic [NUM_REQ-1:0] gnt
);

    logic [LW-1:0] idx;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = LW'((int'(last_gnt) + k) % NUM_REQ);
            gnt = req[idx] ? NUM_REQ'(1) << idx : gnt;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin FIFO write arbiter with credit tracking; FIFO_WR_ARB_GRANT_CNT_EN adds grant_cnt
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = DEF_NUM_REQ,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CW         = $clog2(FIFO_DEPTH + 1),
    localparam int LW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_rd_en,
    input  logic                          fifo_empty,
    input  logic                          fifo_full,
    output logic [CW-1:0]                 credits,
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
    output logic [15:0]                   grant_cnt,
`endif
    output logic                          ovf_err
);

    arb_state_e            state_q, state_d;
    logic [LW-1:0]         last_q, last_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  cs_q;
    logic                  ovf_q, ovf_d;
    logic [NUM_REQ-1:0]    pick;
    logic                  xfer, rd_acc, rd_eff;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req      (req),
        .last_gnt (last_q),
        .gnt      (pick)
    );

    always_comb begin
        rd_acc    = fifo_rd_en && !fifo_empty;
        rd_eff    = rd_acc && credits_q != CW'(FIFO_DEPTH);
        gnt       = (rst_n && state_q == ARB && credits_q != '0) ? pick : '0;
        xfer      = |gnt;
        credits_d = credits_q - CW'(xfer) + CW'(rd_eff);
        last_d    = xfer ? LW'(oh2idx(8'(gnt))) : last_q;
        wr_en_d   = xfer;
        data_d    = xfer ? req_data[last_d*DATA_WIDTH +: DATA_WIDTH] : data_q;
        ovf_d     = ovf_q || (wr_en_q && fifo_full && !rd_acc);
        state_d   = state_q;
        unique case (state_q)
            IDLE:    state_d = |req ? (credits_q == '0 ? STALL : ARB) : IDLE;
            ARB:     state_d = credits_d == '0 ? STALL : (|req ? ARB : IDLE);
            STALL:   state_d = credits_q != '0 ? ARB : STALL;
            default: state_d = IDLE;
        endcase
    end

`ifdef FIFO_WR_ARB_GRANT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb cnt_d = (xfer && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk)
        cnt_q <= !rst_n ? '0 : cnt_d;

    assign grant_cnt = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= LW'(NUM_REQ - 1);
            credits_q <= CW'(FIFO_DEPTH);
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            cs_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            credits_q <= credits_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            cs_q      <= 1'b1;
            ovf_q     <= ovf_d;
        end
    end

    assign fifo_cs      = cs_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign credits      = credits_q;
    assign ovf_err      = ovf_q;

endmodule
